// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse width meter: FSM state encoding and
// default geometry.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int W_DEF         = 8;
  localparam int MIN_WIDTH_DEF = 1;

endpackage

// File: rtl/pulse_meter_edge.sv
// Input front end for the pulse meter: registers PIN and flags its rising
// edge. Define PULSE_METER_SYNC_EN for a 2-flop synchronizer on PIN when it
// comes from a source asynchronous to CLK; otherwise PIN is registered once.
module pulse_meter_edge (
  input  logic CLK,
  input  logic R_N,
  input  logic PIN,
  output logic pin_q,
  output logic rise
);

  logic pin_d_q;

`ifdef PULSE_METER_SYNC_EN
  logic pin_meta_q;

  // Two-stage synchronizer followed by the one-cycle delay used for edge detect.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      pin_meta_q <= 1'b0;
      pin_q      <= 1'b0;
      pin_d_q    <= 1'b0;
    end else begin
      pin_meta_q <= PIN;
      pin_q      <= pin_meta_q;
      pin_d_q    <= pin_q;
    end
  end
`else
  // Single input register followed by the one-cycle delay used for edge detect.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      pin_q   <= 1'b0;
      pin_d_q <= 1'b0;
    end else begin
      pin_q   <= PIN;
      pin_d_q <= pin_q;
    end
  end
`endif

  assign rise = pin_q & ~pin_d_q;

endmodule

// File: rtl/pulse_meter.sv
// Pulse width meter: counts how many CLK samples PIN stays high and hands the
// width to a consumer through a VALID/READY handshake. Widths saturate at
// 2^W-1 with OVF set; pulses shorter than MIN_WIDTH are dropped silently;
// a rising edge while a result is pending is dropped and flagged on MISS.
// Build option PULSE_METER_SYNC_EN (in pulse_meter_edge) adds a synchronizer
// stage on PIN and one cycle of latency.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int MIN_WIDTH = MIN_WIDTH_DEF
) (
  input  logic         CLK,
  input  logic         R_N,
  input  logic         PIN,
  output logic [W-1:0] RESULT,
  output logic         OVF,
  output logic         VALID,
  input  logic         READY,
  output logic         MISS
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W:0]   MIN_CMP = MIN_WIDTH[W:0];

  state_e       state_q, state_d;
  logic [W-1:0] count_q;
  logic         ovf_q;
  logic [W-1:0] result_q;
  logic         ovf_out_q;
  logic         valid_q;
  logic         miss_q;

  logic pin_q;
  logic rise;
  logic meets_min;
  logic load_cnt, inc_cnt, capture, ack, miss_d;

  pulse_meter_edge u_edge (
    .CLK   (CLK),
    .R_N   (R_N),
    .PIN   (PIN),
    .pin_q (pin_q),
    .rise  (rise)
  );

  assign meets_min = ({1'b0, count_q} >= MIN_CMP);

  // State register.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: a measurement only starts on a fresh rise seen in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rise) state_d = MEAS;
      MEAS: if (!pin_q) state_d = meets_min ? DONE : IDLE;
      DONE: if (valid_q && READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: datapath controls derived from the current state.
  always_comb begin
    load_cnt = 1'b0;
    inc_cnt  = 1'b0;
    capture  = 1'b0;
    ack      = 1'b0;
    miss_d   = 1'b0;
    case (state_q)
      IDLE: load_cnt = rise;
      MEAS: begin
        inc_cnt = pin_q;
        capture = !pin_q && meets_min;
      end
      DONE: begin
        ack    = valid_q && READY;
        miss_d = rise;
      end
      default: ;
    endcase
  end

  // Width counter with sticky overflow, result registers and MISS strobe.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      count_q   <= '0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
      ovf_out_q <= 1'b0;
      valid_q   <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      if (load_cnt) begin
        count_q <= CNT_ONE;
        ovf_q   <= 1'b0;
      end else if (inc_cnt) begin
        if (count_q == CNT_MAX) ovf_q   <= 1'b1;
        else                    count_q <= count_q + CNT_ONE;
      end else if (ack) begin
        ovf_q <= 1'b0;
      end

      if (capture) begin
        result_q  <= count_q;
        ovf_out_q <= ovf_q;
        valid_q   <= 1'b1;
      end else if (ack) begin
        valid_q <= 1'b0;
      end

      miss_q <= miss_d;
    end
  end

  assign RESULT = result_q;
  assign OVF    = ovf_out_q;
  assign VALID  = valid_q;
  assign MISS   = miss_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: a W=8/MIN_WIDTH=1 instance for width, latency,
// back-pressure and reset cases, and a MIN_WIDTH=3 instance for the
// short-pulse filter. Expected widths go into per-instance queues when a
// pulse is driven and are popped when VALID rises.
module tb_pulse_meter;

`ifdef PULSE_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       CLK   = 1'b0;
  logic       R_N   = 1'b1;
  logic       READY = 1'b1;
  logic       pin_a = 1'b0;
  logic       pin_b = 1'b0;
  logic [7:0] res_a, res_b;
  logic       ovf_a, ovf_b, valid_a, valid_b, miss_a, miss_b;

  pulse_meter #(.W(8), .MIN_WIDTH(1)) dut (
    .CLK(CLK), .R_N(R_N), .PIN(pin_a), .RESULT(res_a), .OVF(ovf_a),
    .VALID(valid_a), .READY(READY), .MISS(miss_a)
  );

  pulse_meter #(.W(8), .MIN_WIDTH(3)) dut3 (
    .CLK(CLK), .R_N(R_N), .PIN(pin_b), .RESULT(res_b), .OVF(ovf_b),
    .VALID(valid_b), .READY(READY), .MISS(miss_b)
  );

  always #5 CLK = ~CLK;

  typedef struct { int k; int res; int ovf; } vec_t;
  typedef struct { int res; int ovf; } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   checks   = 0;
  int   errors   = 0;
  int   miss_cnt = 0;
  int   vrise_b  = 0;
  logic va_prev  = 1'b0;
  logic vb_prev  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int res, input int ovf);
    exp_t e;
    e.res = res;
    e.ovf = ovf;
    return e;
  endfunction

  // Scoreboard monitors: compare on each rising VALID, count MISS cycles.
  always @(negedge CLK) begin
    if (miss_a) miss_cnt++;
    if (R_N && valid_a && !va_prev) begin
      if (q_a.size() == 0) check("unexpected_valid_a", 1, 0);
      else begin
        ea = q_a.pop_front();
        check("result_a", int'(res_a), ea.res);
        check("ovf_a", int'(ovf_a), ea.ovf);
      end
    end
    va_prev = valid_a;
    if (R_N && valid_b && !vb_prev) begin
      vrise_b++;
      if (q_b.size() == 0) check("unexpected_valid_b", 1, 0);
      else begin
        eb = q_b.pop_front();
        check("result_b", int'(res_b), eb.res);
        check("ovf_b", int'(ovf_b), eb.ovf);
      end
    end
    vb_prev = valid_b;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_a(input int k);
    pin_a = 1'b1;
    repeat (k) tick();
    pin_a = 1'b0;
  endtask

  task automatic pulse_b(input int k);
    pin_b = 1'b1;
    repeat (k) tick();
    pin_b = 1'b0;
  endtask

  // Edges from PIN going low until VALID is seen (bounded).
  task automatic wait_valid_a(output int n);
    n = 0;
    while (!valid_a && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid_b(output int n);
    n = 0;
    while (!valid_b && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[7];
    int   n;

    tbl[0] = '{k: 5,   res: 5,   ovf: 0};
    tbl[1] = '{k: 1,   res: 1,   ovf: 0};
    tbl[2] = '{k: 2,   res: 2,   ovf: 0};
    tbl[3] = '{k: 17,  res: 17,  ovf: 0};
    tbl[4] = '{k: 255, res: 255, ovf: 0};
    tbl[5] = '{k: 256, res: 255, ovf: 1};
    tbl[6] = '{k: 300, res: 255, ovf: 1};

    #2 R_N = 1'b0;
    repeat (2) tick();
    check("rst_result", int'(res_a), 0);
    check("rst_ovf", int'(ovf_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_miss", int'(miss_a), 0);
    check("rst_valid_b", int'(valid_b), 0);
    R_N = 1'b1;
    repeat (3) tick();

    // Width sweep with READY held high.
    for (int i = 0; i < 7; i++) begin
      q_a.push_back(mk(tbl[i].res, tbl[i].ovf));
      pulse_a(tbl[i].k);
      wait_valid_a(n);
      check("valid_latency", n, 1 + LAT);
      tick();
      check("valid_one_cycle", int'(valid_a), 0);
      repeat (4) tick();
    end

    // Back-pressure: second pulse arrives while the first result is pending.
    READY = 1'b0;
    q_a.push_back(mk(4, 0));
    pulse_a(4);
    wait_valid_a(n);
    check("bp_latency", n, 1 + LAT);
    repeat (2) tick();
    miss_cnt = 0;
    pulse_a(6);
    repeat (6) tick();
    check("bp_valid_held", int'(valid_a), 1);
    check("bp_result_held", int'(res_a), 4);
    check("bp_miss_once", miss_cnt, 1);
    READY = 1'b1;
    tick();
    check("bp_valid_cleared", int'(valid_a), 0);
    repeat (12) tick();
    check("bp_no_second", int'(valid_a), 0);

    // Reset for one cycle in the middle of a 10-cycle pulse.
    pin_a = 1'b1;
    repeat (3) tick();
    R_N = 1'b0;
    #1;
    check("arst_result", int'(res_a), 0);
    check("arst_valid", int'(valid_a), 0);
    check("arst_miss", int'(miss_a), 0);
    tick();
    R_N = 1'b1;
    q_a.push_back(mk(6, 0));
    repeat (6) tick();
    pin_a = 1'b0;
    wait_valid_a(n);
    check("arst_latency", n, 1 + LAT);
    repeat (4) tick();

    // Minimum-width filter on the MIN_WIDTH=3 instance.
    pulse_b(2);
    repeat (6) tick();
    check("short_no_valid", vrise_b, 0);
    q_b.push_back(mk(3, 0));
    pulse_b(3);
    wait_valid_b(n);
    check("minw_latency", n, 1 + LAT);
    repeat (4) tick();
    check("minw_one_result", vrise_b, 1);

    check("sb_a_drained", q_a.size(), 0);
    check("sb_b_drained", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 Parameter W, default 8, is the width counter and RESULT width in bits, with a legal range of 2..16.
REQ-002 Parameter MIN_WIDTH, default 1, is the minimum accepted pulse width in CLK cycles; shorter pulses are discarded.
REQ-003 Port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port R_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port PIN, input, 1 bit: the pulse to be measured, e.g. a TIMER OUT.
REQ-006 Port RESULT, output, W bits: measured high width in CLK samples.
REQ-007 Port OVF, output, 1 bit: the width saturated at 2^W-1; qualified by VALID.
REQ-008 Port VALID, output, 1 bit: RESULT and OVF hold a measurement.
REQ-009 Port READY, input, 1 bit: the consumer accepts the measurement.
REQ-010 Port MISS, output, 1 bit: one-cycle pulse when a rising edge is dropped.

Function
REQ-011 Sampled input pin_q is PIN registered once, or through two flops with PULSE_METER_SYNC_EN; pin_d is pin_q delayed one cycle; rise = pin_q & ~pin_d.
REQ-012 The FSM has exactly three states: IDLE, MEAS, DONE.
REQ-013 IDLE with rise shall load count=1 and go to MEAS; otherwise it stays in IDLE.
REQ-014 MEAS with pin_q=1 shall increment count, saturating at 2^W-1 with no wrap; a sticky ovf sets when an increment is blocked.
REQ-015 MEAS with pin_q=0 and count>=MIN_WIDTH shall register RESULT=count and OVF=ovf, assert VALID, and go to DONE.
REQ-016 MEAS with pin_q=0 and count<MIN_WIDTH shall go to IDLE with no VALID and no MISS.
REQ-017 A pulse sampled high for k consecutive cycles shall give RESULT=min(k, 2^W-1).
REQ-018 Latency: VALID rises 1 cycle after the first CLK edge sampling PIN low (2 cycles with the macro).
REQ-019 DONE shall hold RESULT, OVF and VALID stable until a cycle with VALID&READY; that cycle goes to IDLE, clears VALID, and clears ovf.
REQ-020 A rise in DONE, including the handshake cycle, shall be dropped and MISS pulsed for 1 cycle; the FSM never starts a measurement mid-pulse.
REQ-021 After a handshake with PIN still high, measurement resumes only at the next rising edge.
REQ-022 READY while VALID=0 shall have no effect.

Reset
REQ-023 R_N=0 shall asynchronously force state=IDLE, count=0, ovf=0, RESULT=0, OVF=0, VALID=0, MISS=0, and all pin flops to 0.
REQ-024 Reset mid-MEAS or mid-DONE shall discard the measurement with no VALID; a PIN already high at release is treated as a new rise.

Configuration
REQ-025 Macro PULSE_METER_SYNC_EN defined shall add a 2-flop synchronizer on PIN, for asynchronous sources, adding one cycle of latency.
REQ-026 Macro PULSE_METER_SYNC_EN undefined shall use a single input register, for sources synchronous to CLK; function is otherwise identical.

Structure
REQ-027 Shared package pulse_meter_pkg shall hold the state encoding constants (IDLE=2'd0, MEAS=2'd1, DONE=2'd2) and the default W and MIN_WIDTH.
REQ-028 The edge/sync front end shall be sub-module pulse_meter_edge (outputs pin_q, rise); the FSM, counter and output registers stay in pulse_meter.

Verification
REQ-029 W=8, MIN_WIDTH=1, READY=1, PIN high 5 cycles -> RESULT=5, OVF=0, VALID high 1 cycle, at the latency of REQ-018.
REQ-030 W=8, PIN high 300 cycles -> RESULT=255, OVF=1.
REQ-031 MIN_WIDTH=3, PIN high 2 cycles then 3 cycles -> first pulse gives no VALID; second gives RESULT=3.
REQ-032 READY=0, pulses of 4 then 6 cycles -> RESULT holds 4 with VALID held, MISS pulses once; after READY=1, VALID drops and no RESULT=6 appears.
REQ-033 R_N low for 1 cycle at cycle 3 of a 10-cycle pulse -> outputs 0 immediately, no VALID for that pulse.
REQ-034 Both macro settings run the REQ-029 stimulus -> identical RESULT, with VALID exactly one cycle later when the macro is defined.
